// File: rtl/led_output_driver_pkg.sv
// LED output driver shared definitions.
// Mode encodings and board clock constants.
package led_output_driver_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    localparam int CLOCK_FREQ = 125_000_000;

    // Prescale for a target PWM frequency at CLOCK_FREQ.
    function automatic int tick_count_for(int pwm_hz, int pwm_bits);
        return CLOCK_FREQ / (pwm_hz << pwm_bits);
    endfunction

endpackage

// File: rtl/led_timebase.sv
// LED timebase: prescaler, PWM counter and blink phase.
// Exposes next-state values so outputs can register in step.
module led_timebase #(
    parameter int TICK_COUNT_MAX    = 488,
    parameter int PWM_BITS          = 8,
    parameter int BLINK_PERIODS_MAX = 250
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] pwm_nxt,
    output logic                phase_nxt,
    output logic                wrap_evt,
    output logic                period_start
);

    localparam int PS_W = (TICK_COUNT_MAX > 1) ?
                          $clog2(TICK_COUNT_MAX) : 1;
    localparam int BL_W = (BLINK_PERIODS_MAX > 1) ?
                          $clog2(BLINK_PERIODS_MAX) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_COUNT_MAX - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_PERIODS_MAX - 1);

    logic [PS_W-1:0]     presc;
    logic [PS_W-1:0]     presc_nxt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BL_W-1:0]     blink_cnt;
    logic [BL_W-1:0]     blink_nxt;
    logic                blink_phase;
    logic                tick;

    // Next-state for the prescaler, PWM step and blink counters.
    always_comb begin
        tick      = (presc == PS_LAST);
        presc_nxt = tick ? '0 : presc + PS_W'(1);
        pwm_nxt   = tick ? pwm_cnt + PWM_BITS'(1) : pwm_cnt;
        wrap_evt  = tick && (&pwm_cnt);
        blink_nxt = blink_cnt;
        phase_nxt = blink_phase;
        if (wrap_evt) begin
            if (blink_cnt == BL_LAST) begin
                blink_nxt = '0;
                phase_nxt = ~blink_phase;
            end else begin
                blink_nxt = blink_cnt + BL_W'(1);
            end
        end
    end

    // Counter registers; period_start marks pwm_cnt returning to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            pwm_cnt      <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc        <= presc_nxt;
            pwm_cnt      <= pwm_nxt;
            blink_cnt    <= blink_nxt;
            blink_phase  <= phase_nxt;
            period_start <= wrap_evt;
        end
    end

endmodule

// File: rtl/led_output_driver.sv
// LED output driver: off/on/blink/PWM per LED.
// Config writes are staged and applied at PWM period boundaries.
module led_output_driver
    import led_output_driver_pkg::*;
#(
    parameter int WIDTH             = 6,
    parameter int TICK_COUNT_MAX    = 488,
    parameter int PWM_BITS          = 8,
    parameter int BLINK_PERIODS_MAX = 250,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                period_start,
    output logic [WIDTH-1:0]    leds
);

    logic [PWM_BITS-1:0] pwm_nxt;
    logic                phase_nxt;
    logic                wrap_evt;

    logic                pending;
    logic [IDX_W-1:0]    stg_idx;
    led_mode_e           stg_mode;
    logic [PWM_BITS-1:0] stg_duty;

    led_mode_e           mode_q [WIDTH];
    led_mode_e           mode_d [WIDTH];
    logic [PWM_BITS-1:0] duty_q [WIDTH];
    logic [PWM_BITS-1:0] duty_d [WIDTH];
    logic [WIDTH-1:0]    led_d;

    logic accept;
    logic commit;

    led_timebase #(
        .TICK_COUNT_MAX   (TICK_COUNT_MAX),
        .PWM_BITS         (PWM_BITS),
        .BLINK_PERIODS_MAX(BLINK_PERIODS_MAX)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .pwm_nxt     (pwm_nxt),
        .phase_nxt   (phase_nxt),
        .wrap_evt    (wrap_evt),
        .period_start(period_start)
    );

    assign cfg_ready = !pending;
    assign accept    = cfg_valid && !pending;
    assign commit    = wrap_evt && pending;

    // Apply a committing entry, then pick each LED's next drive level.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mode_d[i] = mode_q[i];
            duty_d[i] = duty_q[i];
            if (commit && (stg_idx == IDX_W'(i))) begin
                mode_d[i] = stg_mode;
                duty_d[i] = stg_duty;
            end
            unique case (mode_d[i])
                LED_OFF:   led_d[i] = 1'b0;
                LED_ON:    led_d[i] = 1'b1;
                LED_BLINK: led_d[i] = phase_nxt;
                LED_PWM:   led_d[i] = (pwm_nxt < duty_d[i]);
                default:   led_d[i] = 1'b0;
            endcase
        end
    end

    // Single-entry staging buffer; an accepted entry waits for a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            stg_idx  <= '0;
            stg_mode <= LED_OFF;
            stg_duty <= '0;
        end else if (accept) begin
            pending  <= 1'b1;
            stg_idx  <= cfg_idx;
            stg_mode <= led_mode_e'(cfg_mode);
            stg_duty <= cfg_duty;
        end else if (commit) begin
            pending  <= 1'b0;
        end
    end

    // Per-LED config and the registered LED drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                mode_q[i] <= LED_OFF;
                duty_q[i] <= '0;
            end
            leds <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                mode_q[i] <= mode_d[i];
                duty_q[i] <= duty_d[i];
            end
            leds <= led_d;
        end
    end

endmodule

// File: tb/tb_led_output_driver.sv
// Testbench for led_output_driver.
// Time-based reference model with a per-cycle scoreboard.
module tb_led_output_driver;

    localparam int TICK = 2;
    localparam int PB   = 3;
    localparam int BLK  = 2;
    // WIDTH=5 so that indices 5..7 fit cfg_idx yet are out of range.
    localparam int W    = 5;
    localparam int IW   = 3;
    localparam int PER  = TICK * (1 << PB);
    localparam int HALF = PER * BLK;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [IW-1:0] cfg_idx = '0;
    logic [1:0]    cfg_mode = '0;
    logic [PB-1:0] cfg_duty = '0;
    logic          period_start;
    logic [W-1:0]  leds;

    led_output_driver #(
        .WIDTH            (W),
        .TICK_COUNT_MAX   (TICK),
        .PWM_BITS         (PB),
        .BLINK_PERIODS_MAX(BLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idx     (cfg_idx),
        .cfg_mode    (cfg_mode),
        .cfg_duty    (cfg_duty),
        .period_start(period_start),
        .leds        (leds)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] leds;
        logic         ps;
        logic         rdy;
    } obs_t;

    typedef struct {
        int idx;
        int mode;
        int duty;
        int exp_hi;
    } vec_t;

    obs_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    int t = 0;
    bit in_rst = 1'b1;
    bit pend = 1'b0;
    int s_idx, s_mode, s_duty;
    int m_mode[W];
    int m_duty[W];
    bit last_acc, last_commit;

    function automatic logic [W-1:0] exp_leds();
        logic [W-1:0] e = '0;
        if (!in_rst) begin
            for (int i = 0; i < W; i++) begin
                case (m_mode[i])
                    1: e[i] = 1'b1;
                    2: e[i] = ((t / HALF) % 2) == 1;
                    3: e[i] = ((t / TICK) % (1 << PB)) < m_duty[i];
                    default: e[i] = 1'b0;
                endcase
            end
        end
        return e;
    endfunction

    task automatic model_edge();
        bit wrap;
        last_acc = 1'b0;
        last_commit = 1'b0;
        in_rst = rst;
        if (rst) begin
            t = 0;
            pend = 1'b0;
            for (int i = 0; i < W; i++) begin
                m_mode[i] = 0;
                m_duty[i] = 0;
            end
        end else begin
            wrap = (t % PER) == PER - 1;
            if (cfg_valid && !pend) begin
                pend = 1'b1;
                s_idx = int'(cfg_idx);
                s_mode = int'(cfg_mode);
                s_duty = int'(cfg_duty);
                last_acc = 1'b1;
            end else if (wrap && pend) begin
                if (s_idx < W) begin
                    m_mode[s_idx] = s_mode;
                    m_duty[s_idx] = s_duty;
                end
                pend = 1'b0;
                last_commit = 1'b1;
            end
            t++;
        end
    endtask

    task automatic step();
        obs_t e, g;
        model_edge();
        e.leds = exp_leds();
        e.ps   = !in_rst && t > 0 && (t % PER) == 0;
        e.rdy  = !pend;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sbq.pop_front();
        g = {leds, period_start, cfg_ready};
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL cycle t=%0d leds/ps/rdy got %b/%b/%b want %b/%b/%b",
                     t, g.leds, g.ps, g.rdy, e.leds, e.ps, e.rdy);
        end
    endtask

    task automatic check(string nm, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic issue(int idx, int mode, int duty);
        bit ok = 1'b0;
        cfg_valid = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_mode  = 2'(mode);
        cfg_duty  = PB'(duty);
        for (int k = 0; k < 64 && !ok; k++) begin
            step();
            ok = last_acc;
        end
        cfg_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_commit();
        bit ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            step();
            ok = last_commit;
        end
        if (!ok) check("commit_timeout", 0, 1);
    endtask

    initial begin
        vec_t tbl[7];
        int   hi, n, cstep, astep, nchg, lt;
        logic prev;

        tbl[0] = '{1, 3, 3, 6};
        tbl[1] = '{1, 3, 0, 0};
        tbl[2] = '{1, 3, 7, 14};
        tbl[3] = '{2, 1, 0, 16};
        tbl[4] = '{2, 0, 5, 0};
        tbl[5] = '{4, 3, 1, 2};
        tbl[6] = '{3, 3, 4, 8};

        repeat (3) step();
        check("rst_leds", int'(leds), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_ps", int'(period_start), 0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            issue(tbl[k].idx, tbl[k].mode, tbl[k].duty);
            check("ready_low_staged", int'(cfg_ready), 0);
            wait_commit();
            check("ps_at_commit", int'(period_start), 1);
            hi = int'(leds[tbl[k].idx]);
            for (int c = 1; c < PER; c++) begin
                step();
                hi += int'(leds[tbl[k].idx]);
            end
            check($sformatf("high_cycles_vec%0d", k), hi, tbl[k].exp_hi);
        end

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("midrst_leds", int'(leds), 0);
        check("midrst_ready", int'(cfg_ready), 1);
        for (n = 1; n <= 40; n++) begin
            step();
            if (period_start) break;
        end
        check("first_ps_delay", n, PER);

        issue(0, 2, 0);
        wait_commit();
        prev = leds[0];
        nchg = 0;
        lt = -1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (leds[0] !== prev) begin
                nchg++;
                check("blink_at_ps", int'(period_start), 1);
                if (lt >= 0) check("blink_interval", t - lt, HALF);
                lt = t;
                prev = leds[0];
            end
        end
        check("blink_toggle_count", int'(nchg >= 3), 1);

        cfg_valid = 1'b1;
        cfg_idx = 3'd2;
        cfg_mode = 2'd1;
        cfg_duty = '0;
        for (int k = 0; k < 64; k++) begin
            step();
            if (last_acc) break;
        end
        cfg_idx = 3'd3;
        cstep = -100;
        astep = 0;
        for (int k = 1; k < 64; k++) begin
            step();
            if (last_commit) begin
                cstep = k;
                check("bp_first_visible", int'(leds[3:2]), 1);
                check("bp_first_ps", int'(period_start), 1);
            end
            if (last_acc) begin
                astep = k;
                break;
            end
        end
        cfg_valid = 1'b0;
        check("bp_accept_after_commit", astep - cstep, 1);
        wait_commit();
        check("bp_second_visible", int'(leds[3:2]), 3);

        for (int k = 0; k < 40 && (t % PER) != PER - 1; k++) step();
        cfg_valid = 1'b1;
        cfg_idx = 3'd4;
        cfg_mode = 2'd1;
        step();
        cfg_valid = 1'b0;
        check("race_accepted", int'(last_acc), 1);
        check("race_not_applied", int'(leds[4]), 0);
        for (n = 1; n <= 40; n++) begin
            step();
            if (leds[4]) break;
        end
        check("race_deferred", n, PER);

        for (int k = 5; k < 8; k += 2) begin
            issue(k, 1, 7);
            wait_commit();
            check("oor_leds", int'(leds), int'(exp_leds()));
            check("oor_ready", int'(cfg_ready), 1);
        end

        issue(1, 1, 0);
        check("pend_before_rst", int'(cfg_ready), 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_drops_pending", int'(cfg_ready), 1);
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            hi += int'(leds[1]);
        end
        check("discarded_entry", hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
